// File: rtl/player_motion_if.sv
// Player position bus: carries the sprite top-edge row and flight status from
// the motion controller (master) to the player drawing logic (slave).
//   luc_loc_o  : 9-bit sprite top-edge y-coordinate
//   airborne_o : high while the player is rising or falling
//   landed_o   : one-cycle pulse on touchdown
interface player_motion_if;
  logic [8:0] luc_loc_o;
  logic       airborne_o;
  logic       landed_o;

  modport master (output luc_loc_o, airborne_o, landed_o);
  modport slave  (input  luc_loc_o, airborne_o, landed_o);
endinterface

// File: rtl/player_motion.sv
// player_motion: frame-rate jump/gravity controller for the player sprite.
// Ports:
//   clk_i        : system/pixel clock
//   rst_i        : asynchronous active-high reset
//   frame_tick_i : one-cycle pulse per frame; all motion updates happen here
//   jump_i       : synchronized, debounced jump button level
//   loc_if       : player_motion_if.master (luc_loc_o, airborne_o, landed_o)
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one mid-air jump
// per flight.
module player_motion #(
  parameter int unsigned PlayerHeight = 60,
  parameter int unsigned ScreenHeight = 480,
  parameter int unsigned JumpVelocity = 12,
  parameter int unsigned Gravity      = 1,
  parameter int unsigned MaxFall      = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_tick_i,
  input  logic jump_i,
  player_motion_if.master loc_if
);

  localparam int unsigned GroundY = ScreenHeight - PlayerHeight;
  localparam logic [8:0]  GroundY9 = 9'(GroundY);
  localparam logic [5:0]  JumpV6   = 6'(JumpVelocity);
  localparam logic [5:0]  Grav6    = 6'(Gravity);
  localparam logic [5:0]  MaxFall6 = 6'(MaxFall);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t     r_state;
  logic [8:0] r_pos;
  logic [5:0] r_spd;
  logic       r_jump_q;
  logic       r_pending;
  logic       r_landed;

  logic       w_edge;
  logic       w_req;
  logic       w_dbl;
  logic       w_top_clamp;
  logic [8:0] w_rise_pos;
  logic [5:0] w_rise_spd;
  logic [9:0] w_fall_new;
  logic [6:0] w_fall_sum;
  logic [5:0] w_fall_spd;

  // A same-cycle edge counts toward the tick it coincides with.
  assign w_edge = jump_i & ~r_jump_q;
  assign w_req  = r_pending | w_edge;

  assign w_top_clamp = r_pos < 9'(r_spd);
  assign w_rise_pos  = r_pos - 9'(r_spd);
  assign w_rise_spd  = (r_spd > Grav6) ? (r_spd - Grav6) : 6'd0;
  // 10-bit sum so a fast fall near the bottom cannot wrap past 511.
  assign w_fall_new  = 10'(r_pos) + 10'(r_spd);
  assign w_fall_sum  = 7'(r_spd) + 7'(Grav6);
  assign w_fall_spd  = (w_fall_sum > 7'(MaxFall6)) ? MaxFall6 : w_fall_sum[5:0];

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic r_extra;
  assign w_dbl = w_req & r_extra;
`else
  assign w_dbl = 1'b0;
`endif

  // Request capture, state, speed and position; motion only on frame ticks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_GROUND;
      r_pos     <= GroundY9;
      r_spd     <= 6'd0;
      r_jump_q  <= 1'b0;
      r_pending <= 1'b0;
      r_landed  <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      r_extra   <= 1'b1;
`endif
    end else begin
      r_jump_q <= jump_i;
      r_landed <= 1'b0;
      if (frame_tick_i) begin
        r_pending <= 1'b0;
      end else if (w_edge) begin
        r_pending <= 1'b1;
      end

      if (frame_tick_i) begin
        case (r_state)
          ST_GROUND: begin
            r_pos <= GroundY9;
            if (w_req) begin
              r_state <= ST_RISE;
              r_spd   <= JumpV6;
            end
          end
          ST_RISE, ST_FALL: begin
            if (w_dbl) begin
              // Mid-air relaunch: position held, speed reloaded upward.
              r_state <= ST_RISE;
              r_spd   <= JumpV6;
`ifdef PLAYER_DOUBLE_JUMP_EN
              r_extra <= 1'b0;
`endif
            end else if (r_state == ST_RISE) begin
              if (w_top_clamp) begin
                r_pos   <= 9'd0;
                r_spd   <= 6'd0;
                r_state <= ST_FALL;
              end else begin
                r_pos <= w_rise_pos;
                r_spd <= w_rise_spd;
                if (w_rise_spd == 6'd0) r_state <= ST_FALL;
              end
            end else begin
              if (w_fall_new >= 10'(GroundY9)) begin
                r_pos    <= GroundY9;
                r_spd    <= 6'd0;
                r_state  <= ST_GROUND;
                r_landed <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
                r_extra  <= 1'b1;
`endif
              end else begin
                r_pos <= w_fall_new[8:0];
                r_spd <= w_fall_spd;
              end
            end
          end
          default: begin
            r_state <= ST_GROUND;
            r_pos   <= GroundY9;
            r_spd   <= 6'd0;
          end
        endcase
      end
    end
  end

  assign loc_if.luc_loc_o  = r_pos;
  assign loc_if.airborne_o = (r_state != ST_GROUND);
  assign loc_if.landed_o   = r_landed;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: constant trajectory table, hand
// sequences for reset/edge/hold/clamp corners, and randomized traffic checked
// against a signed-velocity behavioural model.
module tb_player_motion;

  localparam int GY = 420;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick1 = 1'b0, jump1 = 1'b0;
  logic tick2 = 1'b0, jump2 = 1'b0;

  player_motion_if if1 ();
  player_motion_if if2 ();

  player_motion dut1 (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick1), .jump_i(jump1), .loc_if(if1.master)
  );

  player_motion #(.JumpVelocity(63), .Gravity(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick2), .jump_i(jump2), .loc_if(if2.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: signed vertical velocity, negative means upward.
  typedef struct {
    int pos; int vy; int mode;  // mode 0 ground, 1 up, 2 down
    bit pend; bit jq; bit landed; bit extra;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mreset();
    mdl_t s;
    s.pos = GY; s.vy = 0; s.mode = 0;
    s.pend = 0; s.jq = 0; s.landed = 0; s.extra = 1;
    return s;
  endfunction

  function automatic mdl_t mstep(mdl_t s_in, bit tick, bit jump, int jv);
    mdl_t s = s_in;
    bit edge_seen = jump && !s.jq;
    bit req = s.pend || edge_seen;
    bit dbl = 0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dbl = req && s.extra;
`endif
    s.landed = 0;
    if (tick) begin
      if (s.mode == 0) begin
        if (req) begin s.mode = 1; s.vy = -jv; end
      end else if (dbl) begin
        s.mode = 1; s.vy = -jv; s.extra = 0;
      end else if (s.mode == 1) begin
        if (s.pos + s.vy < 0) begin
          s.pos = 0; s.vy = 0; s.mode = 2;
        end else begin
          s.pos += s.vy;
          s.vy += 1;
          if (s.vy >= 0) begin s.vy = 0; s.mode = 2; end
        end
      end else begin
        if (s.pos + s.vy >= GY) begin
          s.pos = GY; s.vy = 0; s.mode = 0; s.landed = 1; s.extra = 1;
        end else begin
          s.pos += s.vy;
          s.vy = (s.vy + 1 > 12) ? 12 : s.vy + 1;
        end
      end
      s.pend = 0;
    end else if (edge_seen) begin
      s.pend = 1;
    end
    s.jq = jump;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance models at posedge, compare 1ns later.
  task automatic cyc(input bit t, input bit j, input bit t2, input bit j2);
    @(negedge clk);
    tick1 = t; jump1 = j; tick2 = t2; jump2 = j2;
    @(posedge clk);
    m1 = mstep(m1, t, j, 12);
    m2 = mstep(m2, t2, j2, 63);
    #1;
    chk("pos1", int'(if1.luc_loc_o), m1.pos);
    chk("air1", int'(if1.airborne_o), int'(m1.mode != 0));
    chk("land1", int'(if1.landed_o), int'(m1.landed));
    chk("pos2", int'(if2.luc_loc_o), m2.pos);
    chk("air2", int'(if2.airborne_o), int'(m2.mode != 0));
    chk("land2", int'(if2.landed_o), int'(m2.landed));
  endtask

  // Tick DUT1 until it is back on the ground, with a bounded budget.
  task automatic fly_out1();
    int n = 0;
    while ((if1.airborne_o || m1.mode != 0) && n < 80) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    if (if1.airborne_o) chk("fly_out_timeout", 1, 0);
  endtask

  typedef struct { bit tick; bit jump; int pos; bit air; bit land; } vec_t;
  vec_t vq[$];

  function automatic void add(bit t, bit j, int p, bit a, bit l);
    vec_t v;
    v.tick = t; v.jump = j; v.pos = p; v.air = a; v.land = l;
    vq.push_back(v);
  endfunction

  int rise_tab[12] = '{408, 397, 387, 378, 370, 363, 357, 352, 348, 345, 343, 342};
  int fall_tab[13] = '{342, 343, 345, 348, 352, 357, 363, 370, 378, 387, 397, 408, 420};

  initial begin
    int landings;
    int minpos, maxpos;
    bit j;

    m1 = mreset(); m2 = mreset();

    // Full-jump table, each tick followed by an idle cycle to check stability.
    add(0, 1, GY, 0, 0);
    add(0, 0, GY, 0, 0);
    add(1, 0, GY, 1, 0);
    add(0, 0, GY, 1, 0);
    for (int i = 0; i < 12; i++) begin
      add(1, 0, rise_tab[i], 1, 0);
      add(0, 0, rise_tab[i], 1, 0);
    end
    for (int i = 0; i < 12; i++) begin
      add(1, 0, fall_tab[i], 1, 0);
      add(0, 0, fall_tab[i], 1, 0);
    end
    add(1, 0, fall_tab[12], 0, 1);
    add(0, 0, GY, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", int'(if1.luc_loc_o), GY);
    chk("rst_air", int'(if1.airborne_o), 0);
    chk("rst_land", int'(if1.landed_o), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      cyc(vq[i].tick, vq[i].jump, 0, 0);
      chk($sformatf("tab_pos[%0d]", i), int'(if1.luc_loc_o), vq[i].pos);
      chk($sformatf("tab_air[%0d]", i), int'(if1.airborne_o), int'(vq[i].air));
      chk($sformatf("tab_land[%0d]", i), int'(if1.landed_o), int'(vq[i].land));
    end

    // Edge in the same cycle as a tick launches on that tick.
    cyc(1, 1, 0, 0);
    chk("same_cycle_launch", int'(if1.airborne_o), 1);
    cyc(0, 0, 0, 0);
    fly_out1();

    // Edge 5 cycles before the tick, released before it.
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("early_edge_launch", int'(if1.airborne_o), 1);
    chk("early_edge_pos", int'(if1.luc_loc_o), GY);

    // Second edge mid-flight (discarded unless double jump is built in).
    repeat (12) cyc(1, 0, 0, 0);
    chk("apex", int'(if1.luc_loc_o), 342);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
`ifdef PLAYER_DOUBLE_JUMP_EN
    chk("dbl_hold", int'(if1.luc_loc_o), 342);
    cyc(1, 0, 0, 0);
    chk("dbl_rise", int'(if1.luc_loc_o), 330);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("third_ignored", int'(if1.luc_loc_o), 319);
`else
    chk("second_edge_ignored", int'(if1.luc_loc_o), 342);
    cyc(1, 0, 0, 0);
    chk("second_edge_fall", int'(if1.luc_loc_o), 343);
`endif
    cyc(0, 0, 0, 0);
    fly_out1();

    // Held button across several flight durations: exactly one jump.
    landings = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(i % 2 == 1, 1, 0, 0);
      if (if1.landed_o) landings++;
    end
    chk("held_landings", landings, 1);
    cyc(0, 0, 0, 0);

    // Top clamp on the fast-jump instance.
    minpos = GY; maxpos = 0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 1, 0);
      if (int'(if2.luc_loc_o) < minpos) minpos = int'(if2.luc_loc_o);
      if (int'(if2.luc_loc_o) > maxpos) maxpos = int'(if2.luc_loc_o);
    end
    chk("clamp_min", minpos, 0);
    chk("clamp_max", maxpos, GY);
    chk("clamp_grounded", int'(if2.airborne_o), 0);

    // Asynchronous reset mid-flight.
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    @(negedge clk);
    tick1 = 0; jump1 = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_pos", int'(if1.luc_loc_o), GY);
    chk("midrst_air", int'(if1.airborne_o), 0);
    chk("midrst_land", int'(if1.landed_o), 0);
    m1 = mreset(); m2 = mreset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized ticks and button activity on both instances.
    j = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) j = ~j;
      cyc($urandom_range(0, 2) == 0, j, $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
